// File: rtl/data_mem_bridge_pkg.sv
// Shared state encoding, access-size codes and byte-lane helpers for the data memory bridge.
package data_mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  // Access size as carried by funct3[1:0]; 2'b11 is handled like a word.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << a;
      SZ_H:    be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      SZ_B:    w = {4{d[7:0]}};
      SZ_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] a);
    logic [1:0] off;
    case (size)
      SZ_B:    off = a;
      SZ_H:    off = {a[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = a[0];
      default: bad = (a != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_bridge_mem_lane_align.sv
// Combinational byte-lane steering: store byte enables / replicated data on the way out,
// right-justified zero-extended load data on the way back.
module mem_lane_align
  import data_mem_bridge_pkg::*;
(
  input  logic [1:0]  reqSize_i,
  input  logic [1:0]  reqAddr_i,
  input  logic [31:0] reqWdata_i,
  output logic [3:0]  reqBe_o,
  output logic [31:0] reqWdata_o,
  output logic [1:0]  reqOff_o,
  input  logic [1:0]  rspSize_i,
  input  logic [1:0]  rspOff_i,
  input  logic [31:0] rspRdata_i,
  output logic [31:0] rspRdata_o
);

  logic [31:0] shifted;

  always_comb begin
    reqBe_o    = be_of(reqSize_i, reqAddr_i);
    reqWdata_o = lane_wdata(reqSize_i, reqWdata_i);
    reqOff_o   = lane_off(reqSize_i, reqAddr_i);
  end

  // Bring the addressed lane down to bit 0, then clear everything above the access size.
  always_comb begin
    shifted = rspRdata_i >> {rspOff_i, 3'b000};
    case (rspSize_i)
      SZ_B:    rspRdata_o = {24'h000000, shifted[7:0]};
      SZ_H:    rspRdata_o = {16'h0000, shifted[15:0]};
      default: rspRdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_bridge.sv
// Bridges single-cycle CPU load/store strobes onto a valid/ready word bus and stalls the CPU meanwhile.
// Define ALIGN_CHECK_EN to trap misaligned half/word accesses instead of silently aligning them.
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int ADDR_W         = 30,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_write,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [1:0]        i_size,
  output logic              o_stall,
  output logic [31:0]       o_rdata,
  output logic              o_buserr,
  output logic              o_misalign,
  output logic              o_bus_valid,
  input  logic              i_bus_ready,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [3:0]        o_bus_be,
  output logic [31:0]       o_bus_wdata,
  input  logic              i_bus_rvalid,
  input  logic [31:0]       i_bus_rdata
);

  // Wide enough to hold TIMEOUT_CYCLES+1 so a late accept cannot wrap the counter.
  localparam int               CNT_W  = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cntInc;
  logic [ADDR_W-1:0] busAddr_q, busAddr_d;
  logic              busWe_q, busWe_d;
  logic [3:0]        busBe_q, busBe_d;
  logic [31:0]       busWdata_q, busWdata_d;
  logic [1:0]        rspOff_q, rspOff_d;
  logic [1:0]        rspSize_q, rspSize_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              buserr_q, buserr_d;

  logic              cpuReq;
  logic              timeoutHit;
  logic              badAlign;
  logic [3:0]        reqBe;
  logic [31:0]       reqWdata;
  logic [1:0]        reqOff;
  logic [31:0]       rspWord;

  mem_lane_align u_lane (
    .reqSize_i  (i_size),
    .reqAddr_i  (i_addr[1:0]),
    .reqWdata_i (i_wdata),
    .reqBe_o    (reqBe),
    .reqWdata_o (reqWdata),
    .reqOff_o   (reqOff),
    .rspSize_i  (rspSize_q),
    .rspOff_i   (rspOff_q),
    .rspRdata_i (i_bus_rdata),
    .rspRdata_o (rspWord)
  );

  assign cpuReq     = i_load | i_write;
  assign cntInc     = cnt_q + CNT_W'(1);
  assign timeoutHit = (TIMEOUT_CYCLES != 0) && (cntInc >= TO_LIM);

`ifdef ALIGN_CHECK_EN
  logic misalign_q;

  assign badAlign = misaligned(i_size, i_addr[1:0]);

  always_ff @(posedge i_clk) begin
    if (i_rst) misalign_q <= 1'b0;
    else       misalign_q <= (state_q == IDLE) && cpuReq && badAlign;
  end

  assign o_misalign = misalign_q;
`else
  assign badAlign   = 1'b0;
  assign o_misalign = 1'b0;
`endif

  // Completion (accept / rvalid) takes priority over a timeout landing in the same cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busAddr_d  = busAddr_q;
    busWe_d    = busWe_q;
    busBe_d    = busBe_q;
    busWdata_d = busWdata_q;
    rspOff_d   = rspOff_q;
    rspSize_d  = rspSize_q;
    rdata_d    = rdata_q;
    buserr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cpuReq && badAlign) begin
          state_d = DONE;
          rdata_d = '0;
        end else if (cpuReq) begin
          state_d    = REQ;
          busAddr_d  = i_addr[ADDR_W+1:2];
          busWe_d    = i_write;
          busBe_d    = reqBe;
          busWdata_d = reqWdata;
          rspOff_d   = reqOff;
          rspSize_d  = i_size;
        end
      end
      REQ: begin
        cnt_d = cntInc;
        if (i_bus_ready) begin
          state_d = busWe_q ? DONE : RESP;
        end else if (timeoutHit) begin
          state_d  = DONE;
          buserr_d = 1'b1;
          rdata_d  = '0;
        end
      end
      RESP: begin
        cnt_d = cntInc;
        if (i_bus_rvalid) begin
          state_d = DONE;
          rdata_d = rspWord;
        end else if (timeoutHit) begin
          state_d  = DONE;
          buserr_d = 1'b1;
          rdata_d  = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busAddr_q  <= '0;
      busWe_q    <= 1'b0;
      busBe_q    <= 4'b0000;
      busWdata_q <= 32'h0;
      rspOff_q   <= 2'b00;
      rspSize_q  <= 2'b00;
      rdata_q    <= 32'h0;
      buserr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busAddr_q  <= busAddr_d;
      busWe_q    <= busWe_d;
      busBe_q    <= busBe_d;
      busWdata_q <= busWdata_d;
      rspOff_q   <= rspOff_d;
      rspSize_q  <= rspSize_d;
      rdata_q    <= rdata_d;
      buserr_q   <= buserr_d;
    end
  end

  assign o_stall     = ((state_q == IDLE) && cpuReq) || (state_q == REQ) || (state_q == RESP);
  assign o_bus_valid = (state_q == REQ);
  assign o_bus_we    = busWe_q;
  assign o_bus_addr  = busAddr_q;
  assign o_bus_be    = busBe_q;
  assign o_bus_wdata = busWdata_q;
  assign o_rdata     = rdata_q;
  assign o_buserr    = buserr_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Bench for data_mem_bridge: randomized loads/stores checked against a byte-lane arithmetic model,
// plus directed reset-in-flight, timeout (second instance, TIMEOUT_CYCLES=4) and alignment cases.
module tb_data_mem_bridge;

  logic        i_clk = 1'b0;
  logic        i_rst, i_load, i_write;
  logic [31:0] i_addr, i_wdata;
  logic [1:0]  i_size;
  logic        i_bus_ready, i_bus_rvalid;
  logic [31:0] i_bus_rdata;

  logic        stall, buserr, misalign, busValid, busWe;
  logic [31:0] rdata, busWdata;
  logic [29:0] busAddr;
  logic [3:0]  busBe;

  logic        toStall, toBuserr, toMisalign, toBusValid, toBusWe;
  logic [31:0] toRdata, toBusWdata;
  logic [29:0] toBusAddr;
  logic [3:0]  toBusBe;

  int          compareCount = 0;
  int          failCount    = 0;
  logic [31:0] modelRdata;

`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  data_mem_bridge dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_write(i_write),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_size(i_size),
    .o_stall(stall), .o_rdata(rdata), .o_buserr(buserr), .o_misalign(misalign),
    .o_bus_valid(busValid), .i_bus_ready(i_bus_ready), .o_bus_we(busWe),
    .o_bus_addr(busAddr), .o_bus_be(busBe), .o_bus_wdata(busWdata),
    .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata)
  );

  data_mem_bridge #(.TIMEOUT_CYCLES(4)) dutTo (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_write(i_write),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_size(i_size),
    .o_stall(toStall), .o_rdata(toRdata), .o_buserr(toBuserr), .o_misalign(toMisalign),
    .o_bus_valid(toBusValid), .i_bus_ready(i_bus_ready), .o_bus_we(toBusWe),
    .o_bus_addr(toBusAddr), .o_bus_be(toBusBe), .o_bus_wdata(toBusWdata),
    .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic int nBytesOf(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int offsetOf(input logic [1:0] sz, input logic [31:0] addr);
    int n = nBytesOf(sz);
    return ((int'(addr % 4)) / n) * n;
  endfunction

  function automatic bit isMisaligned(input logic [1:0] sz, input logic [31:0] addr);
    return (int'(addr % 4) % nBytesOf(sz)) != 0;
  endfunction

  function automatic logic [3:0] expBe(input logic [1:0] sz, input logic [31:0] addr);
    int n = nBytesOf(sz);
    return 4'(((1 << n) - 1) << offsetOf(sz, addr));
  endfunction

  function automatic logic [31:0] expWdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    int n = nBytesOf(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] expRdata(input logic [1:0] sz, input int off, input logic [31:0] word);
    longint unsigned mask = (64'd1 << (8 * nBytesOf(sz))) - 64'd1;
    longint unsigned w    = 64'(word) >> (8 * off);
    return 32'(w & mask);
  endfunction

  // One CPU access, acting as both CPU and bus; readyWait/rvWait are bus wait cycles.
  task automatic applyStimulus(input bit isStore, input logic [31:0] addr, input logic [1:0] sz,
                               input logic [31:0] wd, input int readyWait, input int rvWait,
                               input logic [31:0] rword);
    int          stalls, validCycles, respCycles, expStall;
    bit          mis, accepted;
    logic [3:0]  be;
    logic [31:0] lane;
    mis      = ALIGN && isMisaligned(sz, addr);
    be       = expBe(sz, addr);
    lane     = expWdata(sz, wd);
    expStall = mis ? 1 : (isStore ? 2 + readyWait : 3 + readyWait + rvWait);
    @(negedge i_clk);
    i_write      = isStore;
    i_load       = isStore ? 1'($urandom_range(0, 1)) : 1'b1;
    i_addr       = addr;
    i_wdata      = wd;
    i_size       = sz;
    i_bus_ready  = 1'b0;
    i_bus_rvalid = 1'($urandom_range(0, 1));
    i_bus_rdata  = $urandom;
    #1;
    stalls = 0; validCycles = 0; respCycles = 0; accepted = 1'b0;
    for (int cyc = 0; cyc < 64 && stall === 1'b1; cyc++) begin
      stalls++;
      if (busValid === 1'b1) begin
        checkOutput("busAddr", 32'(busAddr), {2'b00, addr[31:2]});
        checkOutput("busBe", 32'(busBe), 32'(be));
        checkOutput("busWdata", busWdata, lane);
        checkOutput("busWe", 32'(busWe), 32'(isStore));
        accepted     = (validCycles == readyWait);
        i_bus_ready  = accepted;
        i_bus_rvalid = 1'($urandom_range(0, 1));
        i_bus_rdata  = $urandom;
        validCycles++;
      end else if (accepted) begin
        i_bus_ready  = 1'($urandom_range(0, 1));
        i_bus_rvalid = (respCycles == rvWait);
        i_bus_rdata  = (respCycles == rvWait) ? rword : $urandom;
        respCycles++;
      end else begin
        i_bus_ready  = 1'($urandom_range(0, 1));
        i_bus_rvalid = 1'($urandom_range(0, 1));
      end
      @(negedge i_clk);
      #1;
    end
    if (mis) modelRdata = 32'h0;
    else if (!isStore) modelRdata = expRdata(sz, offsetOf(sz, addr), rword);
    checkOutput("stallCycles", stalls, expStall);
    checkOutput("stallDone", 32'(stall), 32'h0);
    checkOutput("validCycles", validCycles, mis ? 0 : readyWait + 1);
    checkOutput("rdataDone", rdata, modelRdata);
    checkOutput("buserrDone", 32'(buserr), 32'h0);
    checkOutput("misalignDone", 32'(misalign), 32'(mis));
    i_load       = 1'b0;
    i_write      = 1'b0;
    i_bus_ready  = 1'b0;
    i_bus_rvalid = 1'($urandom_range(0, 1));
    @(negedge i_clk);
    #1;
    checkOutput("idleStall", 32'(stall), 32'h0);
    checkOutput("idleValid", 32'(busValid), 32'h0);
    checkOutput("rdataHold", rdata, modelRdata);
    checkOutput("misalignIdle", 32'(misalign), 32'h0);
  endtask

  initial begin
    i_rst = 1'b1; i_load = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0; i_size = '0;
    i_bus_ready = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = '0;
    modelRdata = 32'h0;
    repeat (2) @(negedge i_clk);
    #1;
    checkOutput("rstStall", 32'(stall), 32'h0);
    checkOutput("rstValid", 32'(busValid), 32'h0);
    checkOutput("rstRdata", rdata, 32'h0);
    checkOutput("rstBuserr", 32'(buserr), 32'h0);
    checkOutput("rstMisalign", 32'(misalign), 32'h0);
    checkOutput("rstWe", 32'(busWe), 32'h0);
    checkOutput("rstAddr", 32'(busAddr), 32'h0);
    checkOutput("rstBe", 32'(busBe), 32'h0);
    checkOutput("rstWdata", busWdata, 32'h0);
    checkOutput("rstToValid", 32'(toBusValid), 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Reset while waiting for read data: response arriving afterwards must be dropped.
    @(negedge i_clk);
    i_load = 1'b1; i_addr = 32'h20; i_size = 2'b10; i_bus_ready = 1'b0;
    @(negedge i_clk);
    #1;
    checkOutput("rstSeqValid", 32'(busValid), 32'h1);
    i_bus_ready = 1'b1;
    @(negedge i_clk);
    #1;
    checkOutput("rstSeqRespStall", 32'(stall), 32'h1);
    checkOutput("rstSeqRespValid", 32'(busValid), 32'h0);
    i_bus_ready = 1'b0; i_rst = 1'b1; i_load = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = 32'hDEADBEEF;
    #1;
    checkOutput("rstSeqIdleStall", 32'(stall), 32'h0);
    checkOutput("rstSeqIdleValid", 32'(busValid), 32'h0);
    @(negedge i_clk);
    i_bus_rvalid = 1'b0;
    #1;
    checkOutput("rstSeqNoDone", 32'(stall), 32'h0);
    checkOutput("rstSeqRdata", rdata, 32'h0);
    checkOutput("rstSeqBuserr", 32'(buserr), 32'h0);

    applyStimulus(1'b1, 32'h103, 2'b00, 32'h000000AB, 0, 0, 32'h0);
    applyStimulus(1'b0, 32'h12, 2'b01, 32'h0, 0, 3, 32'hBEEF1234);
    applyStimulus(1'b0, 32'h40, 2'b10, 32'h0, 5, 0, 32'h12345678);
    applyStimulus(1'b0, 32'h87, 2'b00, 32'h0, 1, 1, 32'hA1B2C3D4);
    applyStimulus(1'b0, 32'h84, 2'b11, 32'h0, 0, 0, 32'h0BADF00D);
    applyStimulus(1'b1, 32'h2, 2'b10, 32'hCAFEF00D, 0, 0, 32'h0);
    applyStimulus(1'b0, 32'h13, 2'b01, 32'h0, 0, 1, 32'h89ABCDEF);

    for (int t = 0; t < 40; t++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 3), $urandom);
    end

    // Timeout on the short-limit instance: 4 REQ cycles, then a DONE with buserr.
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    modelRdata = 32'h0;
    applyStimulus(1'b0, 32'h200, 2'b10, 32'h0, 0, 0, 32'h5A5AA5A5);
    checkOutput("toRdataPrev", toRdata, 32'h5A5AA5A5);
    @(negedge i_clk);
    i_load = 1'b1; i_write = 1'b0; i_addr = 32'h300; i_size = 2'b10;
    i_bus_ready = 1'b0; i_bus_rvalid = 1'b0;
    #1;
    checkOutput("toIdleStall", 32'(toStall), 32'h1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge i_clk);
      #1;
      checkOutput("toReqValid", 32'(toBusValid), 32'h1);
      checkOutput("toReqBuserr", 32'(toBuserr), 32'h0);
    end
    @(negedge i_clk);
    #1;
    checkOutput("toBuserrPulse", 32'(toBuserr), 32'h1);
    checkOutput("toRdataZero", toRdata, 32'h0);
    checkOutput("toValidDrop", 32'(toBusValid), 32'h0);
    checkOutput("toStallDone", 32'(toStall), 32'h0);
    checkOutput("noEarlyTimeout", 32'(stall), 32'h1);
    i_load = 1'b0; i_bus_rvalid = 1'b1;
    @(negedge i_clk);
    #1;
    checkOutput("toBuserrClear", 32'(toBuserr), 32'h0);
    checkOutput("toStallIdle", 32'(toStall), 32'h0);
    checkOutput("toRdataHold", toRdata, 32'h0);
    i_bus_rvalid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
